// File: rtl/riscv_mem_pkg.sv
// Shared RV32I load/store definitions: funct3/opcode constants, request struct,
// responder FSM encoding and funct3 legality helper.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic        write;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    // Stores have no unsigned variants.
    function automatic logic f3_legal(input logic write, input logic [2:0] f3);
        if (write)
            return f3 inside {F3_B, F3_H, F3_W};
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for RV32I loads/stores: byte enables,
// replicated store data, load lane extraction with sign/zero extension.
module dmem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);
    localparam int NUM_LANES = 4;
    localparam logic [1:0] SZ_B = F3_B[1:0];
    localparam logic [1:0] SZ_H = F3_H[1:0];
    localparam logic [1:0] SZ_W = F3_W[1:0];

    logic [1:0]  size;
    logic        sign_ext;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign size     = funct3[1:0];
    assign sign_ext = !funct3[2];

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            localparam logic [1:0] LANE = i;
            assign byte_en[i] = (size == SZ_B) ? (addr_lo == LANE) :
                                (size == SZ_H) ? (addr_lo[1] == LANE[1]) : 1'b1;
            // Byte goes to every lane, half to both halves, so the enables pick the target.
            assign wdata_rep[8*i +: 8] = (size == SZ_B) ? wdata[7:0] :
                                         (size == SZ_H) ? wdata[8*(i%2) +: 8] :
                                                          wdata[8*i +: 8];
        end
    endgenerate

    assign rbyte = rword[{addr_lo, 3'b000} +: 8];
    assign rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        rdata_ext = rword;
        case (size)
            SZ_B:    rdata_ext = {{24{sign_ext & rbyte[7]}}, rbyte};
            SZ_H:    rdata_ext = {{16{sign_ext & rhalf[15]}}, rhalf};
            default: rdata_ext = rword;
        endcase
    end

    assign misaligned = ((size == SZ_H) && addr_lo[0]) ||
                        ((size == SZ_W) && (addr_lo != 2'b00));

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, WAIT_STATES latency, one-cycle response.
// Define DMEM_ACCESS_COUNT_EN to add successful load/store counters.
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    output logic [31:0] cnt_load,
    output logic [31:0] cnt_store
`endif
);
    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    dmem_state_t      state, state_nxt;
    dmem_req_t        req_in, req_q, acc;
    logic [3:0]       wcnt;
    logic             accept, enter_resp;
    logic [32:0]      off;
    logic             in_range, acc_err, wr_en;
    logic [IDX_W-1:0] idx;
    logic [3:0]       byte_en;
    logic [31:0]      wdata_rep, rword, rdata_ext;
    logic             misaligned;
    logic [31:0]      mem [DEPTH_WORDS];

    assign req_in    = '{write: req_write, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == RESP);

    always_comb begin
        state_nxt  = state;
        enter_resp = 1'b0;
        case (state)
            IDLE: if (req_valid) begin
                state_nxt  = (WAIT_STATES > 0) ? WAIT : RESP;
                enter_resp = (WAIT_STATES == 0);
            end
            WAIT: if (wcnt == 4'd0) begin
                state_nxt  = RESP;
                enter_resp = 1'b1;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            wcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            if (accept)
                wcnt <= WAIT_LOAD;
            else if (state == WAIT)
                wcnt <= wcnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            req_q <= req_in;
    end

    // With zero wait states the access happens on the accept edge itself.
    assign acc = (state == IDLE) ? req_in : req_q;

    // Borrow out of the 33-bit subtract flags addresses below the base.
    assign off      = {1'b0, acc.addr} - {1'b0, ADDR_BASE};
    assign in_range = !off[32] && (off[31:0] < SPAN);
    assign idx      = off[IDX_W+1:2];
    assign acc_err  = !f3_legal(acc.write, acc.funct3) || misaligned || !in_range;
    assign wr_en    = enter_resp && !reset && acc.write && !acc_err;

    dmem_lane_align u_align (
        .funct3     (acc.funct3),
        .addr_lo    (acc.addr[1:0]),
        .wdata      (acc.wdata),
        .rword      (rword),
        .byte_en    (byte_en),
        .wdata_rep  (wdata_rep),
        .rdata_ext  (rdata_ext),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++)
                if (byte_en[b])
                    mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
        end
    end

    assign rword = mem[idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (enter_resp) begin
            rsp_err   <= acc_err;
            rsp_rdata <= (acc.write || acc_err) ? 32'd0 : rdata_ext;
        end
    end

`ifdef DMEM_ACCESS_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_load  <= 32'd0;
            cnt_store <= 32'd0;
        end else if (state == RESP && !rsp_err) begin
            if (req_q.write)
                cnt_store <= cnt_store + 32'd1;
            else
                cnt_load  <= cnt_load + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder with a byte-addressed reference model;
// three instances cover WAIT_STATES = 1, 0 and 3.
module tb_dmem_responder;
    import riscv_mem_pkg::*;

    localparam int          DEPTH = 64;
    localparam int          NI    = 3;
    localparam logic [31:0] BASE  = 32'h0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst        [NI];
    logic        req_valid  [NI];
    logic        req_ready  [NI];
    logic        req_write  [NI];
    logic [2:0]  req_funct3 [NI];
    logic [31:0] req_addr   [NI];
    logic [31:0] req_wdata  [NI];
    logic        rsp_valid  [NI];
    logic [31:0] rsp_rdata  [NI];
    logic        rsp_err    [NI];
`ifdef DMEM_ACCESS_COUNT_EN
    logic [31:0] cnt_load   [NI];
    logic [31:0] cnt_store  [NI];
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int cur_k  = 0;
    logic [7:0] mdl [NI][DEPTH*4];

    genvar gk;
    generate
        for (gk = 0; gk < NI; gk++) begin : g_dut
            dmem_responder #(
                .DEPTH_WORDS (DEPTH),
                .WAIT_STATES ((gk == 1) ? 0 : (gk == 2) ? 3 : 1),
                .ADDR_BASE   (BASE)
            ) u_dut (
                .clk        (clk),
                .reset      (rst[gk]),
                .req_valid  (req_valid[gk]),
                .req_ready  (req_ready[gk]),
                .req_write  (req_write[gk]),
                .req_funct3 (req_funct3[gk]),
                .req_addr   (req_addr[gk]),
                .req_wdata  (req_wdata[gk]),
                .rsp_valid  (rsp_valid[gk]),
                .rsp_rdata  (rsp_rdata[gk]),
                .rsp_err    (rsp_err[gk])
`ifdef DMEM_ACCESS_COUNT_EN
                ,
                .cnt_load   (cnt_load[gk]),
                .cnt_store  (cnt_store[gk])
`endif
            );
        end
    endgenerate

    function automatic int ws_of(input int k);
        return (k == 1) ? 0 : (k == 2) ? 3 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d (ws=%0d): got %h expected %h", tag, cur_k, ws_of(cur_k), got, exp);
        end
    endtask

    // Reference: memory is a flat byte array, accesses are little-endian byte sums.
    task automatic model(input int k, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic er);
        int     sz;
        longint off, v;
        logic   legal;
        legal = w ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        sz    = 1 << f3[1:0];
        off   = longint'(a) - longint'(BASE);
        er    = !legal || (off < 0) || (off >= DEPTH * 4) || (off % sz != 0);
        rd    = 32'd0;
        if (!er) begin
            if (w) begin
                for (int b = 0; b < sz; b++)
                    mdl[k][int'(off) + b] = 8'(d >> (8 * b));
            end else begin
                v = 0;
                for (int b = 0; b < sz; b++)
                    v = v + (longint'(mdl[k][int'(off) + b]) << (8 * b));
                if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
                    v = v - (longint'(1) << (8 * sz));
                rd = 32'(v);
            end
        end
    endtask

    // One request through the handshake; checks latency, pulse width and response.
    task automatic xfer(input int k, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_er,
                        output logic [31:0] rd, output logic er);
        int n, lat;
        @(negedge clk);
        req_valid[k] = 1'b1; req_write[k] = w; req_funct3[k] = f3;
        req_addr[k] = a; req_wdata[k] = d;
        n = 0;
        while (!req_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_seen", 32'(req_ready[k]), 32'd1);
        @(posedge clk);
        #1 req_valid[k] = 1'b0;
        lat = 1;
        while (!rsp_valid[k] && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("latency", lat, ws_of(k) + 1);
        chk("ready_in_resp", 32'(req_ready[k]), 32'd0);
        rd = rsp_rdata[k];
        er = rsp_err[k];
        chk("rsp_err", 32'(er), 32'(exp_er));
        chk("rsp_rdata", rd, exp_rd);
        @(posedge clk);
        #1;
        chk("pulse_end", 32'(rsp_valid[k]), 32'd0);
        chk("rdata_hold", rsp_rdata[k], exp_rd);
    endtask

    task automatic op(input int k, input logic w, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er);
        logic [31:0] exp_rd;
        logic        exp_er;
        model(k, w, f3, a, d, exp_rd, exp_er);
        xfer(k, w, f3, a, d, exp_rd, exp_er, rd, er);
    endtask

    task automatic test(input int k);
        logic [31:0] rd, a, d;
        logic        er, w;
        logic [2:0]  f3;
        int          last, r;
        logic        ew_t [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  ef_t [5] = '{3'd2, 3'd1, 3'd3, 3'd2, 3'd4};
        logic [31:0] ea_t [5] = '{32'h13, 32'h11, 32'h10, 32'(DEPTH * 4), 32'h10};
        cur_k = k;

        // Word round-trip, lane writes, extension
        op(k, 1'b1, F3_W, 32'h10, 32'h1234_5678, rd, er);
        op(k, 1'b0, F3_W, 32'h10, 32'h0, rd, er);
        chk("rt_lw", rd, 32'h1234_5678);
        op(k, 1'b1, F3_B, 32'h11, 32'h0000_00AB, rd, er);
        op(k, 1'b1, F3_H, 32'h12, 32'h0000_BEEF, rd, er);
        op(k, 1'b0, F3_W, 32'h10, 32'h0, rd, er);
        chk("lane_lw", rd, 32'hBEEF_AB78);
        op(k, 1'b0, F3_B,  32'h11, 32'h0, rd, er); chk("lb",  rd, 32'hFFFF_FFAB);
        op(k, 1'b0, F3_BU, 32'h11, 32'h0, rd, er); chk("lbu", rd, 32'h0000_00AB);
        op(k, 1'b0, F3_H,  32'h12, 32'h0, rd, er); chk("lh",  rd, 32'hFFFF_BEEF);
        op(k, 1'b0, F3_HU, 32'h12, 32'h0, rd, er); chk("lhu", rd, 32'h0000_BEEF);

        for (int i = 0; i < 5; i++) begin
            op(k, ew_t[i], ef_t[i], ea_t[i], 32'hFFFF_FFFF, rd, er);
            chk("err_flag", 32'(er), 32'd1);
            chk("err_rdata", rd, 32'd0);
        end
        op(k, 1'b0, F3_W, 32'h10, 32'h0, rd, er);
        chk("err_nowrite", rd, 32'hBEEF_AB78);

        // Reset while a store waits: it must neither respond nor commit.
        if (ws_of(k) > 0) begin
            op(k, 1'b1, F3_W, 32'h20, 32'h1122_3344, rd, er);
            @(negedge clk);
            req_valid[k] = 1'b1; req_write[k] = 1'b1; req_funct3[k] = F3_W;
            req_addr[k] = 32'h20; req_wdata[k] = 32'hDEAD_BEEF;
            @(posedge clk);
            #1 req_valid[k] = 1'b0;
            rst[k] = 1'b1;
            #1 chk("rst_ready_low", 32'(req_ready[k]), 32'd0);
            @(posedge clk);
            #1 rst[k] = 1'b0;
            #1 chk("rst_ready_after", 32'(req_ready[k]), 32'd1);
`ifdef DMEM_ACCESS_COUNT_EN
            chk("rst_cnt_load", cnt_load[k], 32'd0);
            chk("rst_cnt_store", cnt_store[k], 32'd0);
`endif
            for (int c = 0; c < ws_of(k) + 3; c++) begin
                chk("rst_no_rsp", 32'(rsp_valid[k]), 32'd0);
                @(posedge clk);
                #1;
            end
            op(k, 1'b0, F3_W, 32'h20, 32'h0, rd, er);
            chk("rst_no_commit", rd, 32'h1122_3344);
        end

        // Back-to-back: accepts spaced by WAIT_STATES+2 cycles.
        @(negedge clk);
        req_valid[k] = 1'b1; req_write[k] = 1'b0; req_funct3[k] = F3_W;
        req_addr[k] = 32'h10; req_wdata[k] = 32'h0;
        last = -1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            if (req_ready[k]) begin
                if (last >= 0) chk("b2b_gap", c - last, ws_of(k) + 2);
                last = c;
            end
        end
        req_valid[k] = 1'b0;
        repeat (ws_of(k) + 3) @(posedge clk);

        // Fill the random window so every modelled byte is known.
        for (int i = 0; i < 16; i++)
            op(k, 1'b1, F3_W, 32'(i * 4), $urandom, rd, er);
        for (int i = 0; i < 80; i++) begin
            r  = $urandom_range(0, 9);
            a  = (r < 8) ? 32'($urandom_range(0, 63)) :
                 (r == 8) ? 32'(DEPTH * 4 + $urandom_range(0, 7)) : 32'hFFFF_FFFC;
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            d  = $urandom;
            op(k, w, f3, a, d, rd, er);
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; req_valid[k] = 1'b0; req_write[k] = 1'b0;
            req_funct3[k] = 3'd0; req_addr[k] = 32'd0; req_wdata[k] = 32'd0;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            cur_k = k;
            chk("reset_ready", 32'(req_ready[k]), 32'd0);
            chk("reset_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            chk("reset_rdata", rsp_rdata[k], 32'd0);
            chk("reset_err", 32'(rsp_err[k]), 32'd0);
`ifdef DMEM_ACCESS_COUNT_EN
            chk("reset_cnt_load", cnt_load[k], 32'd0);
            chk("reset_cnt_store", cnt_store[k], 32'd0);
`endif
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            cur_k = k;
            chk("ready_after_reset", 32'(req_ready[k]), 32'd1);
        end
        for (int k = 0; k < NI; k++) test(k);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder that serves the CPU datapath's load/store requests over a valid/ready request channel and a one-cycle response pulse.
- Handles RV32I byte, half and word accesses (LB/LH/LW/LBU/LHU, SB/SH/SW) with little-endian byte lanes and load sign/zero extension.
- Inserts a configurable number of wait states, so the core can be exercised against non-zero memory latency.
- Sits between the core's load/store path and a word-organised storage array.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words in the array; must be a power of two, minimum 4.
- WAIT_STATES, 1: extra cycles between request acceptance and response; valid range 0..15.
- ADDR_BASE, 32'h0000_0000: byte address mapped to word 0; must be word-aligned.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 of the load/store.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (the byte/half sits in the low bits).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load result, already extended; 0 for stores and for errors.
- rsp_err  out  1  request was rejected; meaningful only while rsp_valid = 1.

Behaviour:
- Reset values:
  - State = IDLE; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0.
  - req_ready = 0 while reset is high, and 1 from the first cycle after reset.
  - Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- req_ready = 1 only in IDLE, decoded combinationally from state and reset.
- Acceptance: a request is accepted at an edge where req_valid && req_ready.
  - At that edge, req_write, req_funct3, req_addr and req_wdata are latched.
  - Next state is WAIT if WAIT_STATES > 0, otherwise RESP.
- WAIT: a 4-bit counter is loaded with WAIT_STATES-1 and decremented each cycle; when it reaches 0 the next state is RESP.
- RESP:
  - rsp_valid = 1 for exactly this one cycle; there is no response backpressure.
  - Next state is always IDLE.
  - rsp_rdata and rsp_err stay stable after the pulse until the next RESP.
- Latency:
  - rsp_valid is high in the cycle beginning WAIT_STATES+1 edges after the accept edge.
  - Maximum throughput is one request per WAIT_STATES+2 cycles.
- Storage access:
  - A single array access happens at the edge entering RESP.
  - Word index = (addr - ADDR_BASE) >> 2, using log2(DEPTH_WORDS) bits.
  - Stores write only the addressed lanes, using a byte-enable from funct3 and addr[1:0].
  - Store data is replicated: the byte to all 4 lanes, the half to both halves.
- Load extraction:
  - LB: lane selected by addr[1:0], sign-extended.
  - LBU: same lane, zero-extended.
  - LH: half selected by addr[1], sign-extended.
  - LHU: same half, zero-extended.
  - LW: full word.
- Errors: rsp_err = 1, no array write, rsp_rdata = 0 when any of the following holds:
  - funct3 is illegal for the direction (loads allow 000, 001, 010, 100, 101; stores allow 000, 001, 010);
  - the access is misaligned (half with addr[0] = 1; word with addr[1:0] != 0);
  - the address is out of range (addr < ADDR_BASE, or addr - ADDR_BASE >= DEPTH_WORDS*4).
- Simultaneous events: req_valid is ignored outside IDLE; the requester must hold the request stable until req_ready is seen.
- Reset mid-operation: the pending request is dropped, no write commits, and no rsp_valid is produced.
- Read of a never-written word: returns the array's X/initial content; the bench must not check this value.

Optional Feature:
- Macro: DMEM_ACCESS_COUNT_EN.
- Defined:
  - Adds outputs cnt_load[31:0] and cnt_store[31:0], both reset to 0.
  - Each increments by 1 in RESP for a successful load or store respectively; errors are not counted.
  - Counters wrap from 32'hFFFF_FFFF to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package riscv_mem_pkg holds:
  - funct3 constants F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101;
  - opcode constants OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;
  - the FSM state encoding.
- Sub-module dmem_lane_align: purely combinational. It produces the byte-enable and replicated write data, and performs load-lane extraction and extension. It is reused by the core's store path.

Test Plan:
- Word round-trip: WAIT_STATES=1; SW 0x12345678 to 0x10, then LW 0x10. Each rsp_valid arrives 2 edges after its accept; the LW returns rdata 0x12345678 with err 0.
- Lane writes: after the word above, SB 0xAB to 0x11 and SH 0xBEEF to 0x12. LW 0x10 returns 0xBEEFAB78.
- Load extension: with 0xBEEFAB78 at 0x10:
  - LB 0x11 returns 0xFFFFFFAB; LBU 0x11 returns 0x000000AB;
  - LH 0x12 returns 0xFFFFBEEF; LHU 0x12 returns 0x0000BEEF.
- Errors:
  - LW 0x13, SH 0x11, funct3 = 3'b011 and addr = DEPTH_WORDS*4 each give err = 1 and rdata 0.
  - A following LW 0x10 still returns 0xBEEFAB78, proving no write occurred.
- Latency and handshake: with WAIT_STATES=0, back-to-back req_valid gives req_ready low in RESP and a response every 2 cycles. With WAIT_STATES=3, the response comes 4 edges after accept.
- Reset mid-operation: issue SW 0xDEADBEEF to 0x20, then assert reset in WAIT for one cycle.
  - No rsp_valid appears, and req_ready is 1 on the cycle after reset.
  - A later LW 0x20 returns the previously written value.
  - With DMEM_ACCESS_COUNT_EN defined, the counters read 0 after reset.
